// File: rtl/alt_vipitc130_common_pkg.sv
// Shared definitions for the VIP common trigger schedulers: FSM state
// encoding and width helpers used to size counters and ID buses.
package alt_vipitc130_common_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_FIRE  = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    localparam int unsigned MAX_ACK_TIMEOUT = 32'd65535;
    localparam int unsigned MAX_GAP_CYCLES  = 32'd255;

    // Ceiling log2; clog2(1) is 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        int unsigned span;
        width = 32'd0;
        span  = 32'd1;
        while (span < value) begin
            span  = span << 1;
            width = width + 32'd1;
        end
        return width;
    endfunction

    // Bits needed for a counter running 0..limit-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (clog2(limit) < 32'd1) ? 32'd1 : clog2(limit);
    endfunction

endpackage

// File: rtl/alt_vipitc130_common_trigger_scheduler_if.sv
// Requester / channel side bundle of the trigger scheduler.
// master: the scheduler; slave: requesters plus the far-side ack return.
interface alt_vipitc130_common_trigger_scheduler_if #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
);
    logic [NUM_REQ-1:0]  req;
    logic                ack_done;
    logic                trigger;
    logic [ID_WIDTH-1:0] trigger_id;
    logic                busy;
    logic [NUM_REQ-1:0]  done;
    logic                timeout_err;

    modport master (
        input  req, ack_done,
        output trigger, trigger_id, busy, done, timeout_err
    );

    modport slave (
        output req, ack_done,
        input  trigger, trigger_id, busy, done, timeout_err
    );
endinterface

// File: rtl/alt_vipitc130_common_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last_grant+1
// with wrap-around and reports the first pending index.
module alt_vipitc130_common_rr_arbiter
    import alt_vipitc130_common_pkg::*;
#(
    parameter int N = 4,
    localparam int IDX_W = clog2(N)
) (
    input  logic [N-1:0]     pending,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     grant_onehot,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    localparam int unsigned NU = N;

    // Rotating priority search; the first hit after last_grant wins.
    always_comb begin
        int unsigned idx_v;
        logic        found_v;
        grant_onehot = '0;
        grant_idx    = '0;
        found_v      = 1'b0;
        idx_v        = 32'd0;
        for (int unsigned k = 32'd1; k <= NU; k++) begin
            idx_v = 32'(last_grant) + k;
            if (idx_v >= NU) begin
                idx_v = idx_v - NU;
            end else begin
                idx_v = idx_v;
            end
            if (!found_v && pending[IDX_W'(idx_v)]) begin
                found_v                      = 1'b1;
                grant_idx                    = IDX_W'(idx_v);
                grant_onehot[IDX_W'(idx_v)]  = 1'b1;
            end else begin
                found_v = found_v;
            end
        end
        any = found_v;
    end

endmodule

// File: rtl/alt_vipitc130_common_trigger_scheduler.sv
// Serialises round-robin trigger requests onto a single toggle-based
// clock-crossing trigger channel. trigger_id is a quasi-static side bus,
// held from SETUP until the transaction retires on ack or timeout.
module alt_vipitc130_common_trigger_scheduler
    import alt_vipitc130_common_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ID_WIDTH    = 2,
    parameter int ACK_TIMEOUT = 1023,
    parameter int GAP_CYCLES  = 3
) (
    input logic input_clock,
    input logic input_rst,
    alt_vipitc130_common_trigger_scheduler_if.master sched
);

    localparam int ACK_CNT_W = cnt_width(ACK_TIMEOUT);
    localparam int GAP_CNT_W = cnt_width(GAP_CYCLES);
    localparam logic [ACK_CNT_W-1:0] ACK_LAST = ACK_CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_CYCLES - 1);
    localparam logic [ID_WIDTH-1:0]  LAST_GRANT_RST = ID_WIDTH'(NUM_REQ - 1);

    logic [2:0]           state_r;
    logic [2:0]           state_nxt_s;
    logic [NUM_REQ-1:0]   pending_r;
    logic [ID_WIDTH-1:0]  last_grant_r;
    logic [ID_WIDTH-1:0]  trigger_id_r;
    logic                 trigger_r;
    logic                 busy_r;
    logic [NUM_REQ-1:0]   done_r;
    logic                 timeout_err_r;
    logic [ACK_CNT_W-1:0] ack_cnt_r;
    logic [GAP_CNT_W-1:0] gap_cnt_r;

    logic [NUM_REQ-1:0]   grant_onehot_s;
    logic [ID_WIDTH-1:0]  grant_idx_s;
    logic                 grant_any_s;
    logic                 grant_take_s;
    logic [NUM_REQ-1:0]   grant_clr_s;
    logic [NUM_REQ-1:0]   done_set_s;
    logic                 wait_ack_s;
    logic                 wait_expire_s;

    alt_vipitc130_common_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .pending      (pending_r),
        .last_grant   (last_grant_r),
        .grant_onehot (grant_onehot_s),
        .grant_idx    (grant_idx_s),
        .any          (grant_any_s)
    );

    // Ack beats the final timeout count; ack outside WAIT is ignored.
    assign grant_take_s  = (state_r == ST_IDLE) && grant_any_s;
    assign wait_ack_s    = (state_r == ST_WAIT) && sched.ack_done;
    assign wait_expire_s = (state_r == ST_WAIT) && !sched.ack_done && (ack_cnt_r == ACK_LAST);

    // Next-state selection for the transaction sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  if (grant_any_s) state_nxt_s = ST_SETUP; else state_nxt_s = ST_IDLE;
            ST_SETUP: state_nxt_s = ST_FIRE;
            ST_FIRE:  state_nxt_s = ST_WAIT;
            ST_WAIT:  if (wait_ack_s || wait_expire_s) state_nxt_s = ST_GAP; else state_nxt_s = ST_WAIT;
            ST_GAP:   if (gap_cnt_r == GAP_LAST) state_nxt_s = ST_IDLE; else state_nxt_s = ST_GAP;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Pending-bit clear for the winner and one-hot decode of the done bit.
    always_comb begin
        grant_clr_s = '0;
        done_set_s  = '0;
        if (grant_take_s) begin
            grant_clr_s = grant_onehot_s;
        end else begin
            grant_clr_s = '0;
        end
        if (wait_ack_s) begin
            done_set_s[trigger_id_r] = 1'b1;
        end else begin
            done_set_s = '0;
        end
    end

    // Sequencer state and request capture; a new request beats its own clear.
    always_ff @(posedge input_clock or posedge input_rst) begin
        if (input_rst) begin
            state_r   <= ST_IDLE;
            pending_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            pending_r <= (pending_r & ~grant_clr_s) | sched.req;
        end
    end

    // Grant bookkeeping: winner ID stays on the side bus until the next grant.
    always_ff @(posedge input_clock or posedge input_rst) begin
        if (input_rst) begin
            last_grant_r <= LAST_GRANT_RST;
            trigger_id_r <= '0;
        end else if (grant_take_s) begin
            last_grant_r <= grant_idx_s;
            trigger_id_r <= grant_idx_s;
        end
    end

    // Ack-wait and post-transaction gap counters.
    always_ff @(posedge input_clock or posedge input_rst) begin
        if (input_rst) begin
            ack_cnt_r <= '0;
            gap_cnt_r <= '0;
        end else begin
            if (state_r == ST_FIRE) begin
                ack_cnt_r <= '0;
            end else if (state_r == ST_WAIT) begin
                ack_cnt_r <= ack_cnt_r + 1'b1;
            end
            if (state_r != ST_GAP) begin
                gap_cnt_r <= '0;
            end else begin
                gap_cnt_r <= gap_cnt_r + 1'b1;
            end
        end
    end

    // Registered outputs, all updated on the same edge as the state change.
    always_ff @(posedge input_clock or posedge input_rst) begin
        if (input_rst) begin
            trigger_r     <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            trigger_r     <= (state_nxt_s == ST_FIRE);
            busy_r        <= (state_nxt_s != ST_IDLE);
            done_r        <= done_set_s;
            timeout_err_r <= wait_expire_s;
        end
    end

    assign sched.trigger     = trigger_r;
    assign sched.trigger_id  = trigger_id_r;
    assign sched.busy        = busy_r;
    assign sched.done        = done_r;
    assign sched.timeout_err = timeout_err_r;

endmodule

// File: doc/alt_vipitc130_common_trigger_scheduler.md
Name: alt_vipitc130_common_trigger_scheduler

Overview:
- Serialises trigger requests from NUM_REQ requesters in the input_clock domain onto one shared clock-crossing trigger channel.
- The channel is a toggle-based trigger synchroniser. It carries a single pulse, so the requester ID travels alongside it as a quasi-static bus.
- The scheduler holds trigger_id stable from one cycle before the pulse until the transaction retires (ack or timeout).
- It waits for a far-side acknowledge, already returned into input_clock, before issuing the next trigger.
- Requests are granted round-robin.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..16.
- ID_WIDTH, 2: width of trigger_id; must equal clog2(NUM_REQ).
- ACK_TIMEOUT, 1023: maximum WAIT-state cycles before the transaction is abandoned; legal range 2..65535.
- GAP_CYCLES, 3: idle cycles after each transaction before the next grant; legal range 1..255. Guarantees edge separation at the far-side edge detector.

Ports:
- input_clock, in, 1: scheduler clock.
- input_rst, in, 1: reset, asynchronous, active-high.
- req, in, NUM_REQ: per-requester request. A single-cycle pulse or a level is accepted; a level re-requests after each grant.
- ack_done, in, 1: single-cycle far-side acknowledge, already synchronised into input_clock.
- trigger, out, 1: pulse to the channel trigger_in.
- trigger_id, out, ID_WIDTH: ID of the granted requester; stable from SETUP through WAIT.
- busy, out, 1: high in any state other than IDLE.
- done, out, NUM_REQ: one-cycle pulse on the bit of the acknowledged requester.
- timeout_err, out, 1: one-cycle pulse when a transaction times out.

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE; pending=0; last_grant=NUM_REQ-1, so index 0 wins first.
  - trigger=0, trigger_id=0, busy=0, done=0, timeout_err=0; counters=0.
  - Asserting reset mid-transaction drops trigger immediately and discards all pending requests.
- Pending register: on each edge, pending[i] <= (pending[i] & ~grant_clr[i]) | req[i].
  - If set and clear hit the same bit in the same cycle, set wins.
- Arbiter: combinational round-robin over pending, searching upward from last_grant+1 with wrap-around.
- IDLE: if pending != 0, on the edge:
  - load trigger_id with the winner;
  - update last_grant;
  - clear the winner's pending bit;
  - go to SETUP.
- SETUP: one cycle, trigger=0. Next state FIRE.
- FIRE: trigger=1 for exactly one cycle. Next state WAIT; clear the counter.
- WAIT: trigger=0; counter increments each cycle.
  - ack_done=1: done[trigger_id]=1 next cycle; go to GAP.
  - Otherwise, counter==ACK_TIMEOUT-1: timeout_err=1 next cycle, no done pulse; go to GAP.
  - ack_done together with the final count: ack wins, no timeout.
- GAP: hold GAP_CYCLES cycles, then IDLE. trigger_id keeps its last value.
- ack_done outside WAIT is ignored: no done pulse, no state change.
- Latency:
  - req sampled at edge E0 → SETUP after E1 → trigger high for one cycle after E2.
  - ack_done high in cycle k → done high in cycle k+1.
- Back-to-back minimum: next trigger fires GAP_CYCLES+3 cycles after the ack.
- All outputs registered. The done/timeout_err pulses and the GAP entry are produced on the same edge.

Decomposition:
- Shared package alt_vipitc130_common_pkg:
  - FSM state encoding (IDLE, SETUP, FIRE, WAIT, GAP; 3-bit);
  - clog2 function;
  - counter-width constants derived from ACK_TIMEOUT and GAP_CYCLES.
- One sub-module: alt_vipitc130_common_rr_arbiter.
  - Parameter N.
  - Inputs: pending, last_grant. Outputs: grant_onehot, grant_idx, any.
  - Purely combinational; reusable by the other VIP schedulers.

Test Plan:
- Single request: req[2] pulse at E0 → trigger_id=2 after E1, trigger high one cycle after E2; ack_done 5 cycles later → done=4'b0100 for one cycle; busy drops after GAP_CYCLES=3.
- All four requesters pulse together → grants in order 0,1,2,3, each acked; exactly four trigger pulses; trigger_id never changes while trigger or WAIT is active.
- Timeout: ACK_TIMEOUT=8, no ack → timeout_err pulses 8 cycles after FIRE; done stays 0; the next pending request is then served.
- Ack on the final timeout cycle → done pulses, timeout_err stays 0. A spurious ack_done in IDLE produces no output.
- req[1] held as a level while req[3] pulses once → grants alternate 1,3,1,1 …; pending[1] re-sets in its own grant cycle (set wins).
- input_rst asserted during WAIT → trigger, busy and pending clear immediately. After release, with no new requests, no trigger occurs; a new req[0] produces a normal transaction.
